// File: rtl/getir_pkg.sv
// getir_pkg: shared definitions for the instruction fetch stage.
//   - getir_durum_e : memory-port FSM states (BOSTA / ISTEK / BEKLE)
//   - NOP_VARSAYILAN: instruction driven while the output is invalid (addi x0,x0,0)
//   - rvc_mi()      : RV32C length test, a halfword whose [1:0] != 2'b11 is 16-bit
package getir_pkg;

  typedef enum logic [1:0] {
    GTR_BOSTA = 2'd0,
    GTR_ISTEK = 2'd1,
    GTR_BEKLE = 2'd2
  } getir_durum_e;

  localparam logic [31:0] NOP_VARSAYILAN = 32'h0000_0013;

  function automatic logic rvc_mi(input logic [15:0] yarim);
    return yarim[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/buyruk_hizalayici.sv
// buyruk_hizalayici: combinational 16/32-bit instruction extractor.
//   tampon         : word containing the instruction (or its upper half)
//   tampon_gecerli : tampon holds the word the current PC needs
//   yarim          : saved low half of a straddling 32-bit instruction
//   yarim_gecerli  : yarim holds a pending low half; tampon is the following word
//   ps_1           : PC bit 1 (selects the low or high halfword)
//   buyruk         : extracted instruction, 16-bit ones zero-extended
//   uzun           : 1 = 32-bit instruction, 0 = 16-bit
//   sonraki_gerek  : high half starts a 32-bit instruction; next word is needed
//   gecerli        : buyruk/uzun describe a complete instruction
module buyruk_hizalayici (
  input  logic [31:0] tampon,
  input  logic        tampon_gecerli,
  input  logic [15:0] yarim,
  input  logic        yarim_gecerli,
  input  logic        ps_1,
  output logic [31:0] buyruk,
  output logic        uzun,
  output logic        sonraki_gerek,
  output logic        gecerli
);
  import getir_pkg::*;

  always_comb begin
    buyruk        = '0;
    uzun          = 1'b0;
    sonraki_gerek = 1'b0;
    gecerli       = 1'b0;
    if (yarim_gecerli) begin
      // Second half of a straddling instruction is in the low half of tampon.
      buyruk  = {tampon[15:0], yarim};
      uzun    = 1'b1;
      gecerli = tampon_gecerli;
    end else if (!ps_1) begin
      gecerli = tampon_gecerli;
      if (rvc_mi(tampon[15:0])) begin
        buyruk = {16'h0, tampon[15:0]};
      end else begin
        buyruk = tampon;
        uzun   = 1'b1;
      end
    end else if (rvc_mi(tampon[31:16])) begin
      buyruk  = {16'h0, tampon[31:16]};
      gecerli = tampon_gecerli;
    end else begin
      uzun          = 1'b1;
      sonraki_gerek = tampon_gecerli;
    end
  end

endmodule

// File: rtl/getir.sv
// getir: instruction fetch stage (RV32IC).
// Fetches words over a single-outstanding memory port, realigns 16/32-bit
// instructions and registers one instruction per cycle towards decode.
// PCs are halfword addresses [18:1] (bit 0 of the vectors = address bit 1);
// memory addresses are word addresses [18:2].
//   clk_i, rst_i                   : clock, synchronous active-high reset
//   ddb_durdur_i / ddb_bosalt_i    : stall (hold) / flush the output register
//   ddb_hazir_o                    : cyo_* holds a valid instruction
//   ddb_yanlis_tahmin_o            : redirect taken this cycle (combinational)
//   yrt_atlanan_ps_i / _gecerli_i  : redirect target from execute
//   cyo_buyruk_o, cyo_ps_o, cyo_ps_artmis_o : instruction, its PC, next PC
//   bel_*                          : instruction memory request/response port
module getir #(
  parameter logic [17:0] BASLANGIC_PS = 18'h0,
  parameter logic [31:0] NOP_BUYRUK   = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ddb_durdur_i,
  input  logic        ddb_bosalt_i,
  output logic        ddb_hazir_o,
  output logic        ddb_yanlis_tahmin_o,
  input  logic [17:0] yrt_atlanan_ps_i,
  input  logic        yrt_atlanan_ps_gecerli_i,
  output logic [31:0] cyo_buyruk_o,
  output logic [17:0] cyo_ps_o,
  output logic [17:0] cyo_ps_artmis_o,
  output logic [16:0] bel_adr_o,
  output logic        bel_istek_o,
  input  logic        bel_kabul_i,
  input  logic [31:0] bel_veri_i,
  input  logic        bel_gecerli_i
);
  import getir_pkg::*;

  getir_durum_e durum_r;
  logic [17:0]  ps_r;
  logic [31:0]  tampon_r;
  logic [16:0]  tampon_adr_r;
  logic         tampon_gecerli_r;
  logic [15:0]  yarim_r;
  logic         yarim_gecerli_r;
  logic         at_r;

  logic         yonlendir;
  logic         yanit_al;
  logic [16:0]  ps_kelime, sonraki_kelime, hedef_kelime, istek_kelime;
  logic [31:0]  tampon_gir;
  logic [16:0]  tampon_adr_gir;
  logic         tampon_gecerli_gir;
  logic         isabet;
  logic [31:0]  hz_buyruk;
  logic         hz_uzun, hz_sonraki, hz_gecerli;
  logic [17:0]  ps_artmis;

  assign yonlendir           = yrt_atlanan_ps_gecerli_i;
  assign ddb_yanlis_tahmin_o = yonlendir;

  // Response kept only if it is not stale and no redirect is killing it.
  assign yanit_al = (durum_r == GTR_BEKLE) && bel_gecerli_i && !at_r && !yonlendir;

  assign ps_kelime      = ps_r[17:1];
  assign sonraki_kelime = ps_kelime + 17'd1;
  // With a saved low half the instruction completes in the following word.
  assign hedef_kelime   = yarim_gecerli_r ? sonraki_kelime : ps_kelime;

  // Bypass the arriving word so it can issue in its own response cycle.
  assign tampon_gir         = yanit_al ? bel_veri_i : tampon_r;
  assign tampon_adr_gir     = yanit_al ? bel_adr_o  : tampon_adr_r;
  assign tampon_gecerli_gir = yanit_al | tampon_gecerli_r;
  assign isabet             = tampon_gecerli_gir && (tampon_adr_gir == hedef_kelime);

  buyruk_hizalayici u_hizalayici (
    .tampon         (tampon_gir),
    .tampon_gecerli (isabet),
    .yarim          (yarim_r),
    .yarim_gecerli  (yarim_gecerli_r),
    .ps_1           (ps_r[0]),
    .buyruk         (hz_buyruk),
    .uzun           (hz_uzun),
    .sonraki_gerek  (hz_sonraki),
    .gecerli        (hz_gecerli)
  );

  assign ps_artmis    = ps_r + (hz_uzun ? 18'd2 : 18'd1);
  // A high half being latched this cycle means the next word is what we need.
  assign istek_kelime = (yarim_gecerli_r || hz_sonraki) ? sonraki_kelime : ps_kelime;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_r          <= GTR_BOSTA;
      ps_r             <= BASLANGIC_PS;
      tampon_r         <= '0;
      tampon_adr_r     <= '0;
      tampon_gecerli_r <= 1'b0;
      yarim_r          <= '0;
      yarim_gecerli_r  <= 1'b0;
      at_r             <= 1'b0;
      bel_istek_o      <= 1'b0;
      bel_adr_o        <= '0;
      ddb_hazir_o      <= 1'b0;
      cyo_buyruk_o     <= NOP_BUYRUK;
      cyo_ps_o         <= '0;
      cyo_ps_artmis_o  <= '0;
    end else begin
      if (yanit_al) begin
        tampon_r         <= bel_veri_i;
        tampon_adr_r     <= bel_adr_o;
        tampon_gecerli_r <= 1'b1;
      end

      unique case (durum_r)
        GTR_BOSTA:
          if (!yonlendir && !ddb_durdur_i && !hz_gecerli) begin
            durum_r     <= GTR_ISTEK;
            bel_istek_o <= 1'b1;
            bel_adr_o   <= istek_kelime;
          end
        GTR_ISTEK:
          if (bel_kabul_i) begin
            durum_r     <= GTR_BEKLE;
            bel_istek_o <= 1'b0;
          end
        GTR_BEKLE:
          if (bel_gecerli_i) durum_r <= GTR_BOSTA;
        default: durum_r <= GTR_BOSTA;
      endcase

      // A response arriving with the redirect is dropped right here, so no
      // discard flag is needed for it.
      if (yonlendir && (durum_r == GTR_ISTEK || (durum_r == GTR_BEKLE && !bel_gecerli_i)))
        at_r <= 1'b1;
      else if (durum_r == GTR_BEKLE && bel_gecerli_i)
        at_r <= 1'b0;

      if (yonlendir) begin
        ps_r             <= yrt_atlanan_ps_i;
        tampon_gecerli_r <= 1'b0;
        yarim_gecerli_r  <= 1'b0;
        ddb_hazir_o      <= 1'b0;
        cyo_buyruk_o     <= NOP_BUYRUK;
      end else if (ddb_bosalt_i) begin
        ddb_hazir_o  <= 1'b0;
        cyo_buyruk_o <= NOP_BUYRUK;
      end else if (!ddb_durdur_i) begin
        if (hz_gecerli) begin
          ddb_hazir_o     <= 1'b1;
          cyo_buyruk_o    <= hz_buyruk;
          cyo_ps_o        <= ps_r;
          cyo_ps_artmis_o <= ps_artmis;
          ps_r            <= ps_artmis;
          yarim_gecerli_r <= 1'b0;
        end else begin
          ddb_hazir_o  <= 1'b0;
          cyo_buyruk_o <= NOP_BUYRUK;
          if (hz_sonraki) begin
            yarim_r         <= tampon_gir[31:16];
            yarim_gecerli_r <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_getir.sv
module tb_getir;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ddb_durdur_i, ddb_bosalt_i;
  logic        ddb_hazir_o, ddb_yanlis_tahmin_o;
  logic [17:0] yrt_atlanan_ps_i;
  logic        yrt_atlanan_ps_gecerli_i;
  logic [31:0] cyo_buyruk_o;
  logic [17:0] cyo_ps_o, cyo_ps_artmis_o;
  logic [16:0] bel_adr_o;
  logic        bel_istek_o, bel_kabul_i, bel_gecerli_i;
  logic [31:0] bel_veri_i;

  getir u_dut (
    .clk_i                    (clk_i),
    .rst_i                    (rst_i),
    .ddb_durdur_i             (ddb_durdur_i),
    .ddb_bosalt_i             (ddb_bosalt_i),
    .ddb_hazir_o              (ddb_hazir_o),
    .ddb_yanlis_tahmin_o      (ddb_yanlis_tahmin_o),
    .yrt_atlanan_ps_i         (yrt_atlanan_ps_i),
    .yrt_atlanan_ps_gecerli_i (yrt_atlanan_ps_gecerli_i),
    .cyo_buyruk_o             (cyo_buyruk_o),
    .cyo_ps_o                 (cyo_ps_o),
    .cyo_ps_artmis_o          (cyo_ps_artmis_o),
    .bel_adr_o                (bel_adr_o),
    .bel_istek_o              (bel_istek_o),
    .bel_kabul_i              (bel_kabul_i),
    .bel_veri_i               (bel_veri_i),
    .bel_gecerli_i            (bel_gecerli_i)
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] buyruk;
    logic [17:0] ps;
    logic [17:0] artmis;
    logic        gecikme_chk;
    logic        ardisik_chk;
    logic [7:0]  istek_chk;   // 8'hFF: no request-count check
  } beklenen_t;

  beklenen_t   kuyruk[$];
  beklenen_t   b;
  logic [31:0] bellek [int];
  int kontrol_sayisi = 0, hata_sayisi = 0;
  int cyc = 0, son_gecerli_cyc = 0, son_cikis_cyc = 0, istek_sayisi = 0;
  int gecikme = 0, sayac = 0;
  bit bekliyor = 0;
  logic [16:0] bekleyen_adr = '0;
  logic [16:0] adr;

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    kontrol_sayisi++;
    if (gozlenen !== beklenen) begin
      hata_sayisi++;
      $display("FAIL %s: gozlenen=%h beklenen=%h (cyc %0d)", etiket, gozlenen, beklenen, cyc);
    end
  endtask

  function automatic beklenen_t yap(input logic [31:0] bu, input logic [17:0] p, input logic [17:0] a,
                                     input logic lc, input logic ac, input logic [7:0] ic);
    beklenen_t r;
    r.buyruk = bu; r.ps = p; r.artmis = a;
    r.gecikme_chk = lc; r.ardisik_chk = ac; r.istek_chk = ic;
    return r;
  endfunction

  function automatic logic [31:0] oku(input logic [16:0] a);
    if (bellek.exists(int'(a))) return bellek[int'(a)];
    return 32'h0000_0013;
  endfunction

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // Memory model: one outstanding request, response 'gecikme' cycles after acceptance.
  initial begin
    bel_kabul_i = 1'b0; bel_gecerli_i = 1'b0; bel_veri_i = '0;
    forever begin
      @(posedge clk_i); #1;
      bel_kabul_i = 1'b0; bel_gecerli_i = 1'b0;
      if (rst_i) begin
        bekliyor = 0;
      end else if (bekliyor) begin
        kontrol("tek_bekleyen", {31'h0, bel_istek_o}, 32'h0);
        if (sayac == 0) begin
          bel_gecerli_i   = 1'b1;
          bel_veri_i      = oku(bekleyen_adr);
          bekliyor        = 0;
          son_gecerli_cyc = cyc;
        end else sayac--;
      end else if (bel_istek_o) begin
        bel_kabul_i  = 1'b1;
        bekleyen_adr = bel_adr_o;
        bekliyor     = 1;
        sayac        = gecikme;
        istek_sayisi++;
      end
    end
  end

  // Output monitor: an instruction is consumed when valid and not stalled/flushed.
  initial forever begin
    @(negedge clk_i);
    if (!rst_i && ddb_hazir_o && !ddb_durdur_i && !ddb_bosalt_i && kuyruk.size() != 0) begin
      b = kuyruk.pop_front();
      kontrol("buyruk", cyo_buyruk_o, b.buyruk);
      kontrol("ps", {14'h0, cyo_ps_o}, {14'h0, b.ps});
      kontrol("ps_artmis", {14'h0, cyo_ps_artmis_o}, {14'h0, b.artmis});
      if (b.gecikme_chk) kontrol("getirme_gecikmesi", cyc - son_gecerli_cyc, 32'd1);
      if (b.ardisik_chk) kontrol("ardisik_cikis", cyc - son_cikis_cyc, 32'd1);
      if (b.istek_chk != 8'hFF) kontrol("istek_sayisi", istek_sayisi, {24'h0, b.istek_chk});
      son_cikis_cyc = cyc;
    end
  end

  task automatic sifirla();
    rst_i = 1'b1; ddb_durdur_i = 1'b0; ddb_bosalt_i = 1'b0;
    yrt_atlanan_ps_gecerli_i = 1'b0; yrt_atlanan_ps_i = '0;
    gecikme = 0;
    bellek.delete();
    repeat (2) @(posedge clk_i);
    #2;
    istek_sayisi = 0;
    kontrol("rst_hazir", {31'h0, ddb_hazir_o}, 32'h0);
    kontrol("rst_buyruk", cyo_buyruk_o, 32'h0000_0013);
    kontrol("rst_ps", {14'h0, cyo_ps_o}, 32'h0);
    kontrol("rst_ps_artmis", {14'h0, cyo_ps_artmis_o}, 32'h0);
    kontrol("rst_istek", {31'h0, bel_istek_o}, 32'h0);
    kontrol("rst_adr", {15'h0, bel_adr_o}, 32'h0);
    rst_i = 1'b0;
  endtask

  task automatic bosalmayi_bekle(input int limit);
    int n = 0;
    while (kuyruk.size() != 0 && n < limit) begin
      @(posedge clk_i);
      n++;
    end
    kontrol("cikis_zaman_asimi", kuyruk.size(), 32'd0);
    kuyruk.delete();
  endtask

  task automatic istek_bekle(input int limit, output logic [16:0] a);
    int n = 0;
    #2;
    while (!bel_istek_o && n < limit) begin
      @(posedge clk_i); #2;
      n++;
    end
    kontrol("istek_zaman_asimi", {31'h0, bel_istek_o}, 32'h1);
    a = bel_adr_o;
  endtask

  initial begin
    int n;

    // 1: sequential 32-bit, first request timing
    sifirla();
    bellek[0] = 32'h0050_0093;
    bellek[1] = 32'h0010_0113;
    kuyruk.push_back(yap(32'h0050_0093, 18'd0, 18'd2, 1'b1, 1'b0, 8'hFF));
    kuyruk.push_back(yap(32'h0010_0113, 18'd2, 18'd4, 1'b1, 1'b0, 8'hFF));
    @(posedge clk_i); #2;
    kontrol("ilk_istek", {31'h0, bel_istek_o}, 32'h1);
    kontrol("ilk_adr", {15'h0, bel_adr_o}, 32'h0);
    kontrol("yanlis_tahmin_yok", {31'h0, ddb_yanlis_tahmin_o}, 32'h0);
    bosalmayi_bekle(60);

    // 2: compressed pair from one word, back-to-back, one memory request
    sifirla();
    bellek[0] = 32'h0001_4501;
    kuyruk.push_back(yap(32'h0000_4501, 18'd0, 18'd1, 1'b1, 1'b0, 8'd1));
    kuyruk.push_back(yap(32'h0000_0001, 18'd1, 18'd2, 1'b0, 1'b1, 8'd1));
    bosalmayi_bekle(60);

    // 3: 32-bit instruction straddling a word boundary
    sifirla();
    bellek[0] = 32'h0093_0001;
    bellek[1] = 32'hABCD_0050;
    kuyruk.push_back(yap(32'h0000_0001, 18'd0, 18'd1, 1'b1, 1'b0, 8'hFF));
    kuyruk.push_back(yap(32'h0050_0093, 18'd1, 18'd3, 1'b1, 1'b0, 8'hFF));
    bosalmayi_bekle(60);

    // 4: redirect while waiting for a response; stale data must be dropped
    sifirla();
    gecikme = 3;
    bellek[0]     = 32'h0050_0093;
    bellek[32'h20] = 32'h0010_0113;
    n = 0;
    do begin @(posedge clk_i); #2; n++; end while (!bekliyor && n < 20);
    kontrol("kabul_zaman_asimi", {31'h0, bekliyor}, 32'h1);
    @(posedge clk_i); #2;
    yrt_atlanan_ps_i = 18'h40;
    yrt_atlanan_ps_gecerli_i = 1'b1;
    kuyruk.push_back(yap(32'h0010_0113, 18'h40, 18'h42, 1'b1, 1'b0, 8'hFF));
    #1;
    kontrol("yanlis_tahmin", {31'h0, ddb_yanlis_tahmin_o}, 32'h1);
    @(posedge clk_i); #2;
    yrt_atlanan_ps_gecerli_i = 1'b0;
    istek_bekle(30, adr);
    kontrol("yonlendirme_adr", {15'h0, adr}, 32'h20);
    bosalmayi_bekle(60);

    // 5: stall holds the output, flush invalidates it
    sifirla();
    bellek[0] = 32'h0001_4501;
    n = 0;
    do begin @(posedge clk_i); #2; n++; end while (!ddb_hazir_o && n < 40);
    kontrol("hazir_zaman_asimi", {31'h0, ddb_hazir_o}, 32'h1);
    ddb_durdur_i = 1'b1;
    repeat (3) begin
      @(posedge clk_i); #2;
      kontrol("durdur_buyruk", cyo_buyruk_o, 32'h0000_4501);
      kontrol("durdur_ps", {14'h0, cyo_ps_o}, 32'h0);
      kontrol("durdur_hazir", {31'h0, ddb_hazir_o}, 32'h1);
      kontrol("durdur_istek", {31'h0, bel_istek_o}, 32'h0);
    end
    ddb_durdur_i = 1'b0;
    ddb_bosalt_i = 1'b1;
    kuyruk.push_back(yap(32'h0000_0001, 18'd1, 18'd2, 1'b0, 1'b0, 8'hFF));
    @(posedge clk_i); #2;
    kontrol("bosalt_hazir", {31'h0, ddb_hazir_o}, 32'h0);
    kontrol("bosalt_buyruk", cyo_buyruk_o, 32'h0000_0013);
    ddb_bosalt_i = 1'b0;
    bosalmayi_bekle(40);

    // 6: PC wrap-around from the last halfword
    sifirla();
    bellek[32'h1FFFF] = 32'h4501_0093;
    yrt_atlanan_ps_i = 18'h3FFFF;
    yrt_atlanan_ps_gecerli_i = 1'b1;
    #1;
    kontrol("sarma_yanlis_tahmin", {31'h0, ddb_yanlis_tahmin_o}, 32'h1);
    kuyruk.push_back(yap(32'h0000_4501, 18'h3FFFF, 18'h0, 1'b1, 1'b0, 8'hFF));
    @(posedge clk_i); #2;
    yrt_atlanan_ps_gecerli_i = 1'b0;
    istek_bekle(30, adr);
    kontrol("sarma_ilk_adr", {15'h0, adr}, 32'h1FFFF);
    bosalmayi_bekle(40);
    istek_bekle(30, adr);
    kontrol("sarma_sonraki_adr", {15'h0, adr}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", kontrol_sayisi, hata_sayisi);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulasyon zaman siniri asildi");
    $fatal(1, "watchdog");
  end

endmodule
